// File: rtl/divider_reconstructor_pkg.sv
// Shared definitions for the divider reconstructor: FSM state encoding.
// Imported by the reconstructor top; kept tiny so the divider side can reuse it.
// No logic lives here.
package divider_reconstructor_pkg;

  // Three-phase control: wait for operands, iterate, present result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : divider_reconstructor_pkg

// File: rtl/divider_reconstructor.sv
// Purpose: rebuild the dividend P = Q*B + R by shift-add, one multiplier bit per clock.
// Latency: out_valid rises exactly QW clock edges after the accept edge, independent of operand values.
// Backpressure: operands accepted only in IDLE; the result is held in DONE until out_ready, then IDLE next cycle.
module divider_reconstructor
  import divider_reconstructor_pkg::*;
#(
  parameter int QW = 2,
  parameter int BW = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [QW-1:0]      q_in,
  input  logic [BW-1:0]      b_in,
  input  logic [BW-1:0]      r_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [QW+BW-1:0]   p_out,
  output logic               rem_err
);

  localparam int PW = QW + BW;
  localparam int CW = $clog2(QW + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(QW - 1);

  state_e          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [QW-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rem_err_q, rem_err_d;
  logic [PW-1:0]   p_q, p_d;

  logic            accept;
  logic            run_last;
  logic [PW-1:0]   acc_step;

  assign accept   = (state_q == ST_IDLE) && in_valid;
  assign run_last = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
  // Conditional add of the current multiplicand; wraps at PW bits, which the operand ranges never exceed.
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fixed QW iterations in RUN, no early exit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_RUN;
      ST_RUN:  if (run_last)  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded purely from state, so re-accept waits one cycle after the output handshake.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  // Datapath next values: load on accept, shift-add during RUN, capture result on entry to DONE.
  always_comb begin
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    rem_err_d = rem_err_q;
    p_d       = p_q;
    if (accept) begin
      acc_d     = {{QW{1'b0}}, r_in};
      mcand_d   = {{QW{1'b0}}, b_in};
      mplier_d  = q_in;
      cnt_d     = '0;
      rem_err_d = (r_in >= b_in);
    end else if (state_q == ST_RUN) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (run_last) begin
        p_d = acc_step;
      end
    end
  end

  // Datapath registers; all clear on reset so an aborted run leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      rem_err_q <= 1'b0;
      p_q       <= '0;
    end else begin
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      rem_err_q <= rem_err_d;
      p_q       <= p_d;
    end
  end

  assign p_out   = p_q;
  assign rem_err = rem_err_q;

endmodule : divider_reconstructor
